// File: rtl/wall_follow_ctrl.sv
// Wall-following navigation controller: debounced front/left sensors drive a registered Moore FSM.
// Latency: a stable raw sensor change reaches the filtered value at edge DEB_LEN and the outputs at DEB_LEN+1.
// Backpressure: none; motor commands are level outputs that the driver samples continuously.
module wall_follow_ctrl #(
    parameter int DEB_LEN     = 3,
    parameter int TURN_LEN    = 4,
    parameter int STUCK_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       front_sensor,
    input  logic       left_sensor,
    output logic       front,
    output logic       turn,
    output logic       stuck,
    output logic [2:0] state_out
);

    localparam int DW = $clog2(DEB_LEN + 1);
    localparam int TW = $clog2(TURN_LEN + 1);
    localparam int EW = $clog2(STUCK_LIMIT + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_LEN - 1);
    localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_LEN - 1);
    localparam logic [EW-1:0] EP_LIMIT  = EW'(STUCK_LIMIT);
    localparam logic [EW-1:0] EP_MAX    = {EW{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_FOLLOW = 3'd2,
        ST_TURN   = 3'd3,
        ST_LOST   = 3'd4,
        ST_STUCK  = 3'd5
    } state_t;

    // Bit 0 is the front sensor, bit 1 the left sensor.
    logic [1:0]         raw_dat;
    logic [1:0]         filt;
    logic [1:0][DW-1:0] deb_cnt;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic [EW-1:0] ep_cnt;
    logic [EW-1:0] ep_nxt;
    logic [EW-1:0] ep_inc;
    logic          f;
    logic          l;

    assign raw_dat = {left_sensor, front_sensor};
    assign f       = filt[0];
    assign l       = filt[1];
    assign ep_inc  = (ep_cnt == EP_MAX) ? ep_cnt : ep_cnt + 1'b1;

    // Debounce: the filtered value flips only after DEB_LEN consecutive disagreeing samples.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            filt    <= '0;
            deb_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw_dat[i] != filt[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        filt[i]    <= raw_dat[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Next-state, turn timer and episode counter; a low enable overrides everything.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        ep_nxt    = ep_cnt;
        if (!enable) begin
            state_nxt = ST_IDLE;
            timer_nxt = '0;
            ep_nxt    = '0;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_SEARCH;
                ST_SEARCH: begin
                    if (f) begin
                        state_nxt = ST_TURN;
                        timer_nxt = TURN_LOAD;
                    end else if (l) begin
                        state_nxt = ST_FOLLOW;
                    end
                end
                ST_FOLLOW: begin
                    if (f) begin
                        state_nxt = ST_TURN;
                        timer_nxt = TURN_LOAD;
                    end else if (!l) begin
                        state_nxt = ST_LOST;
                        timer_nxt = TURN_LOAD;
                    end
                end
                ST_TURN, ST_LOST: begin
                    // Sensors are ignored until the episode has run its full length.
                    if (timer != '0) begin
                        timer_nxt = timer - 1'b1;
                    end else begin
                        ep_nxt = ep_inc;
                        if (ep_inc >= EP_LIMIT) begin
                            state_nxt = ST_STUCK;
                        end else if (f) begin
                            state_nxt = ST_TURN;
                            timer_nxt = TURN_LOAD;
                        end else if (l) begin
                            state_nxt = ST_FOLLOW;
                        end else begin
                            state_nxt = ST_SEARCH;
                        end
                    end
                end
                ST_STUCK: state_nxt = ST_STUCK;
                default: begin
                    state_nxt = ST_IDLE;
                    timer_nxt = '0;
                    ep_nxt    = '0;
                end
            endcase
        end
        // Any forward-moving cycle means the robot is making progress again.
        if (state_nxt == ST_SEARCH || state_nxt == ST_FOLLOW) begin
            ep_nxt = '0;
        end
    end

    // State, counters and decoded outputs are all registered so the motor lines never glitch.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            timer  <= '0;
            ep_cnt <= '0;
            front  <= 1'b0;
            turn   <= 1'b0;
            stuck  <= 1'b0;
        end else begin
            state  <= state_nxt;
            timer  <= timer_nxt;
            ep_cnt <= ep_nxt;
            front  <= (state_nxt == ST_SEARCH) || (state_nxt == ST_FOLLOW);
            turn   <= (state_nxt == ST_TURN) || (state_nxt == ST_LOST);
            stuck  <= (state_nxt == ST_STUCK);
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_wall_follow_ctrl.sv
// Bench for wall_follow_ctrl: directed scenarios plus randomized sensor/enable/reset traffic.
// Latency: compares every rising edge against a behavioural model advanced on falling edges.
// Backpressure: not applicable.
module tb_wall_follow_ctrl;

    localparam int DEB_LEN     = 3;
    localparam int TURN_LEN    = 4;
    localparam int STUCK_LIMIT = 4;

    localparam int S_IDLE   = 0;
    localparam int S_SEARCH = 1;
    localparam int S_FOLLOW = 2;
    localparam int S_TURN   = 3;
    localparam int S_LOST   = 4;
    localparam int S_STUCK  = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       front_sensor;
    logic       left_sensor;
    logic       front;
    logic       turn;
    logic       stuck;
    logic [2:0] state_out;

    int errors = 0;
    int checks = 0;

    wall_follow_ctrl #(
        .DEB_LEN    (DEB_LEN),
        .TURN_LEN   (TURN_LEN),
        .STUCK_LIMIT(STUCK_LIMIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .front_sensor(front_sensor),
        .left_sensor (left_sensor),
        .front       (front),
        .turn        (turn),
        .stuck       (stuck),
        .state_out   (state_out)
    );

    always #5 clk = ~clk;

    // Reference model: plain integers describing what the robot is doing.
    int m_state  = 0;
    int m_f      = 0;
    int m_l      = 0;
    int m_run_f  = 0;
    int m_run_l  = 0;
    int m_spent  = 0;  // cycles already spent in the current turn episode
    int m_ep     = 0;  // turn episodes since the last forward cycle
    int m_raw_f;
    int m_raw_l;

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            m_state = S_IDLE;
            m_f = 0; m_l = 0; m_run_f = 0; m_run_l = 0;
            m_spent = 0; m_ep = 0;
        end else begin
            m_raw_f = int'(front_sensor);
            m_raw_l = int'(left_sensor);
            // FSM decisions use the filtered values as they were before this edge.
            if (!enable) begin
                m_state = S_IDLE; m_spent = 0; m_ep = 0;
            end else if (m_state == S_IDLE) begin
                m_state = S_SEARCH;
            end else if (m_state == S_SEARCH) begin
                if (m_f != 0) begin m_state = S_TURN; m_spent = 1; end
                else if (m_l != 0) m_state = S_FOLLOW;
            end else if (m_state == S_FOLLOW) begin
                if (m_f != 0) begin m_state = S_TURN; m_spent = 1; end
                else if (m_l == 0) begin m_state = S_LOST; m_spent = 1; end
            end else if (m_state == S_TURN || m_state == S_LOST) begin
                if (m_spent < TURN_LEN) begin
                    m_spent = m_spent + 1;
                end else begin
                    m_ep = m_ep + 1;
                    if (m_ep >= STUCK_LIMIT) m_state = S_STUCK;
                    else if (m_f != 0) begin m_state = S_TURN; m_spent = 1; end
                    else if (m_l != 0) m_state = S_FOLLOW;
                    else m_state = S_SEARCH;
                end
            end
            if (m_state == S_SEARCH || m_state == S_FOLLOW) m_ep = 0;
            // Debounce: count a run of disagreeing samples, flip once it is long enough.
            if (m_raw_f != m_f) begin
                m_run_f = m_run_f + 1;
                if (m_run_f == DEB_LEN) begin m_f = m_raw_f; m_run_f = 0; end
            end else m_run_f = 0;
            if (m_raw_l != m_l) begin
                m_run_l = m_run_l + 1;
                if (m_run_l == DEB_LEN) begin m_l = m_raw_l; m_run_l = 0; end
            end else m_run_l = 0;
        end
    end

    task automatic check_outs(input string name, input int exp_state);
        logic ef, et, es;
        ef = (exp_state == S_SEARCH) || (exp_state == S_FOLLOW);
        et = (exp_state == S_TURN) || (exp_state == S_LOST);
        es = (exp_state == S_STUCK);
        checks++;
        if (state_out !== 3'(exp_state) || front !== ef || turn !== et || stuck !== es) begin
            errors++;
            $display("FAIL %s @%0t: got state=%0d front=%0b turn=%0b stuck=%0b, expected state=%0d front=%0b turn=%0b stuck=%0b",
                     name, $time, state_out, front, turn, stuck, exp_state, ef, et, es);
        end
    endtask

    // Hand-computed expectation: checks both the DUT and the model against a literal.
    task automatic lit(input string name, input int exp_state);
        check_outs(name, exp_state);
        checks++;
        if (m_state != exp_state) begin
            errors++;
            $display("FAIL model_%s @%0t: model state=%0d, expected %0d", name, $time, m_state, exp_state);
        end
    endtask

    // Every-cycle comparison against the model, away from the falling active edge.
    always @(posedge clk) begin
        if (reset === 1'b0) check_outs("cycle", m_state);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    int rate_f;
    int rate_l;
    int mode;

    initial begin
        reset = 1'b1; enable = 1'b0; front_sensor = 1'b0; left_sensor = 1'b0;
        #1;
        lit("reset_state", S_IDLE);

        // Reset in the middle of a turn acts without a clock.
        @(posedge clk);
        reset = 1'b0; enable = 1'b1; front_sensor = 1'b1;
        cyc(4); lit("turn_entry", S_TURN);
        cyc(1); lit("turn_cycle2", S_TURN);
        #2 reset = 1'b1;
        #1 lit("reset_async", S_IDLE);
        @(posedge clk);
        reset = 1'b0; front_sensor = 1'b0;
        cyc(1); lit("release_search", S_SEARCH);

        // Debounce: a 2-sample glitch is ignored, a held level lands at edge 4.
        left_sensor = 1'b1; cyc(2);
        left_sensor = 1'b0; cyc(2);
        lit("glitch_ignored", S_SEARCH);
        left_sensor = 1'b1; cyc(3);
        lit("deb_edge3", S_SEARCH);
        cyc(1); lit("deb_follow", S_FOLLOW);

        // Obstacle ahead: one 4-cycle turn, then back to following.
        front_sensor = 1'b1; cyc(4);
        lit("obst_turn1", S_TURN);
        front_sensor = 1'b0;
        for (int i = 0; i < 3; i++) begin cyc(1); lit("obst_turn", S_TURN); end
        cyc(1); lit("obst_follow", S_FOLLOW);

        // Stuck: four back-to-back episodes, 16 turning cycles.
        front_sensor = 1'b1; cyc(4);
        for (int i = 0; i < 16; i++) begin lit("stuck_turn", S_TURN); cyc(1); end
        lit("stuck", S_STUCK);
        front_sensor = 1'b0; enable = 1'b0;
        cyc(1); lit("stuck_idle", S_IDLE);
        cyc(2); enable = 1'b1;
        cyc(1); lit("stuck_search", S_SEARCH);
        cyc(1); lit("refollow", S_FOLLOW);

        // Lost wall.
        left_sensor = 1'b0; cyc(4);
        for (int i = 0; i < 4; i++) begin lit("lost_turn", S_LOST); cyc(1); end
        lit("lost_search", S_SEARCH);

        // Enable override mid-LOST, then a full LOST episode afterwards.
        left_sensor = 1'b1; cyc(4); lit("ov_follow", S_FOLLOW);
        left_sensor = 1'b0; cyc(4); lit("ov_lost1", S_LOST);
        cyc(2); lit("ov_lost3", S_LOST);
        enable = 1'b0; cyc(1); lit("ov_idle", S_IDLE);
        enable = 1'b1; cyc(1); lit("ov_search", S_SEARCH);
        left_sensor = 1'b1; cyc(4); lit("ov_follow2", S_FOLLOW);
        left_sensor = 1'b0; cyc(4);
        for (int i = 0; i < 4; i++) begin lit("ov_lost_full", S_LOST); cyc(1); end
        lit("ov_lost_search", S_SEARCH);

        // Randomized traffic; segments vary how bursty the sensors are.
        for (int seg = 0; seg < 60; seg++) begin
            mode = int'($urandom_range(3));
            rate_f = (mode == 0) ? 2 : (mode == 1) ? 8 : 40;
            rate_l = int'($urandom_range(1, 3)) * 6;
            for (int c = 0; c < 40; c++) begin
                @(posedge clk);
                if (mode == 3) front_sensor = 1'b1;
                else if ($urandom_range(rate_f - 1) == 0) front_sensor = ~front_sensor;
                if ($urandom_range(rate_l - 1) == 0) left_sensor = ~left_sensor;
                if (enable) begin
                    if ($urandom_range(99) == 0) enable = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    enable = 1'b1;
                end
                if ($urandom_range(299) == 0) begin
                    #2 reset = 1'b1;
                    #1 lit("rand_reset", S_IDLE);
                    @(posedge clk);
                    reset = 1'b0;
                end
            end
        end

        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
